// File: rtl/fetch_unit_q.sv
// Instruction-fetch stage: PC, in-order memory request/response tracking, fetch queue and
// stage-2 redirect resolution. Optional perf counters are enabled with FETCH_PERF_EN.
module fetch_unit_q #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_vld,
  input  logic               imem_req_rdy,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_vld,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               fq_vld,
  input  logic               fq_rdy,
  output logic [INSTR_W-1:0] fq_instr,
  output logic [ADDR_W-1:0]  fq_pc,
  input  logic               br_vld,
  input  logic [1:0]         br_kind,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [25:0]        br_imm,
  input  logic [ADDR_W-1:0]  br_rdata,
  input  logic               flag_wr,
  input  logic               flag_n,
  input  logic               flag_v,
  output logic               redirect
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_redirects
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OffW = (ADDR_W > 28) ? ADDR_W : 28;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               run_q, run_d;
  logic               lt_q, lt_d;
  logic               redirect_q, redirect_d;
  logic [PtrW-1:0]    fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  logic [CntW-1:0]    fq_cnt_q, fq_cnt_d;
  logic [PtrW-1:0]    tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CntW-1:0]    out_q, out_d;
  logic [CntW-1:0]    drop_q, drop_d;

  logic [ADDR_W-1:0]  tag_mem      [DEPTH];
  logic [ADDR_W-1:0]  fq_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] fq_instr_mem [DEPTH];

  logic               lt, cond, take, accept, rsp, drop_rsp, push, pop;
  logic [CntW:0]      inflight;
  logic [OffW-1:0]    off19, off26;
  logic [ADDR_W-1:0]  target;

  always_comb begin
    lt = flag_wr ? (flag_n ^ flag_v) : lt_q;
    unique case (br_kind)
      2'b00:   cond = br_taken;
      2'b01:   cond = 1'b1;
      2'b10:   cond = 1'b1;
      2'b11:   cond = lt;
      default: cond = 1'b0;
    endcase
    take = br_vld & cond;

    off19 = OffW'($signed(br_imm[18:0])) << 2;
    off26 = OffW'($signed(br_imm[25:0])) << 2;
    unique case (br_kind)
      2'b10:   target = br_rdata;
      2'b01:   target = br_pc + off26[ADDR_W-1:0];
      default: target = br_pc + off19[ADDR_W-1:0];
    endcase

    // Credits cover both in-flight requests and queued words, so the queue can never overflow.
    inflight     = {1'b0, out_q} + {1'b0, fq_cnt_q};
    imem_req_vld = run_q & ~take & (inflight < (CntW + 1)'(DEPTH));
    accept       = imem_req_vld & imem_req_rdy;
    rsp          = imem_rsp_vld & (out_q != '0);
    drop_rsp     = rsp & (drop_q != '0);
    push         = rsp & ~drop_rsp & ~take;
    fq_vld       = (fq_cnt_q != '0);
    pop          = fq_vld & fq_rdy;
  end

  assign imem_addr = pc_q;
  assign fq_instr  = fq_instr_mem[fq_rd_q];
  assign fq_pc     = fq_pc_mem[fq_rd_q];
  assign redirect  = redirect_q;

  always_comb begin
    pc_d       = pc_q;
    run_d      = 1'b1;
    lt_d       = flag_wr ? (flag_n ^ flag_v) : lt_q;
    redirect_d = take;
    out_d      = out_q + CntW'(accept) - CntW'(rsp);
    tag_wr_d   = tag_wr_q + PtrW'(accept);
    tag_rd_d   = tag_rd_q + PtrW'(rsp);
    fq_rd_d    = fq_rd_q + PtrW'(pop);
    fq_wr_d    = fq_wr_q + PtrW'(push);
    fq_cnt_d   = fq_cnt_q + CntW'(push) - CntW'(pop);
    drop_d     = drop_q - CntW'(drop_rsp);
    if (take) begin
      pc_d     = target;
      fq_rd_d  = fq_wr_q;
      fq_cnt_d = '0;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d   = out_q - CntW'(rsp);
    end else if (accept) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      lt_q       <= 1'b0;
      redirect_q <= 1'b0;
      fq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_cnt_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= run_d;
      lt_q       <= lt_d;
      redirect_q <= redirect_d;
      fq_rd_q    <= fq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_cnt_q   <= fq_cnt_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      fq_pc_mem[fq_wr_q]    <= tag_mem[tag_rd_q];
      fq_instr_mem[fq_wr_q] <= imem_rsp_data;
    end
  end

  assert property (@(posedge clk) disable iff (!reset)
                   !(push && !pop && (fq_cnt_q == CntW'(DEPTH))))
    else $fatal(1, "fetch queue overflow");

`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched_q, perf_fetched_d;
  logic [31:0]     perf_flushed_q, perf_flushed_d;
  logic [31:0]     perf_redirects_q, perf_redirects_d;
  logic [CntW-1:0] cleared;
  logic            dropped;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    cleared          = take ? (fq_cnt_q - CntW'(pop)) : '0;
    dropped          = rsp & ((drop_q != '0) | take);
    perf_fetched_d   = sat_add(perf_fetched_q, 32'(push));
    perf_flushed_d   = sat_add(perf_flushed_q, 32'(cleared) + 32'(dropped));
    perf_redirects_d = sat_add(perf_redirects_q, 32'(take));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q   <= '0;
      perf_flushed_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_flushed_q   <= perf_flushed_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_flushed   = perf_flushed_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit_q.sv
// Bench for fetch_unit_q: branch-target vector table, directed corner sequences and a
// randomized run checked against a queue-level model of the fetch stream.
module tb_fetch_unit_q;
  localparam int unsigned AW    = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RPC = '0;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req_vld, imem_req_rdy, imem_rsp_vld;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rsp_data;
  logic          fq_vld, fq_rdy;
  logic [IW-1:0] fq_instr;
  logic [AW-1:0] fq_pc;
  logic          br_vld, br_taken;
  logic [1:0]    br_kind;
  logic [AW-1:0] br_pc, br_rdata;
  logic [25:0]   br_imm;
  logic          flag_wr, flag_n, flag_v;
  logic          redirect;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_flushed, perf_redirects;
`endif

  always #5 clk = ~clk;

  fetch_unit_q #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_addr(imem_addr),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
    .fq_vld(fq_vld), .fq_rdy(fq_rdy), .fq_instr(fq_instr), .fq_pc(fq_pc),
    .br_vld(br_vld), .br_kind(br_kind), .br_taken(br_taken), .br_pc(br_pc),
    .br_imm(br_imm), .br_rdata(br_rdata),
    .flag_wr(flag_wr), .flag_n(flag_n), .flag_v(flag_v),
    .redirect(redirect)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_redirects(perf_redirects)
`endif
  );

  int total = 0;
  int bad = 0;

  // Memory side: addresses the DUT has had accepted, answered in order.
  logic [AW-1:0] mem_pend[$];
  logic [AW-1:0] acc_log[$];
  int            rsp_pct = 0;
  bit            check_en = 0;

  // Reference model of the fetch stream.
  typedef struct {
    logic [AW-1:0] pc;
    bit            stale;
  } pend_t;
  pend_t         m_pend[$];
  logic [AW-1:0] m_fq[$];
  logic [AW-1:0] m_pc;
  bit            m_lt, m_started, m_redirect;

  typedef struct {
    logic          vld;
    logic [1:0]    kind;
    logic          taken;
    logic [AW-1:0] bpc;
    logic [25:0]   imm;
    logic [AW-1:0] rdata;
    logic          fw, fn, fv;
    logic          exp_take;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rsp);
    bit            lt, take, exp_vld;
    longint        off;
    logic [AW-1:0] tgt;
    pend_t         e;
    lt = flag_wr ? (flag_n ^ flag_v) : m_lt;
    case (br_kind)
      2'b00:   take = br_taken;
      2'b11:   take = lt;
      default: take = 1'b1;
    endcase
    take = take && br_vld;
    if (br_kind == 2'b01) off = $signed(br_imm);
    else off = $signed(br_imm[18:0]);
    tgt = (br_kind == 2'b10) ? br_rdata : br_pc + 64'(off * 4);
    exp_vld = m_started && !take && (m_pend.size() + m_fq.size() < DEPTH);

    chk("req_vld", imem_req_vld, exp_vld);
    chk("imem_addr", imem_addr, m_pc);
    chk("fq_vld", fq_vld, m_fq.size() != 0);
    chk("redirect", redirect, m_redirect);
    if (m_fq.size() != 0) begin
      chk("fq_pc", fq_pc, m_fq[0]);
      chk("fq_instr", fq_instr, word_at(m_fq[0]));
    end

    if (fq_rdy && m_fq.size() != 0) m_fq.delete(0);
    if (rsp && m_pend.size() != 0) begin
      e = m_pend[0];
      m_pend.delete(0);
      if (!e.stale && !take) m_fq.push_back(e.pc);
    end
    if (take) begin
      m_fq.delete();
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
      m_pc = tgt;
    end else if (exp_vld && imem_req_rdy) begin
      m_pend.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 64'd4;
    end
    if (flag_wr) m_lt = flag_n ^ flag_v;
    m_redirect = take;
    m_started  = 1'b1;
  endtask

  // One clock: memory drives its response on the falling edge, outputs are sampled just
  // after it, and accepted addresses are recorded after the rising edge.
  task automatic tick();
    logic          acc, rsp;
    logic [AW-1:0] addr;
    @(negedge clk);
    rsp = (mem_pend.size() != 0) && ($urandom_range(99) < rsp_pct);
    imem_rsp_vld  = rsp;
    imem_rsp_data = rsp ? word_at(mem_pend[0]) : '0;
    #1;
    acc  = imem_req_vld && imem_req_rdy;
    addr = imem_addr;
    if (check_en) model_step(rsp);
    @(posedge clk);
    #1;
    if (rsp) mem_pend.delete(0);
    if (acc) begin
      mem_pend.push_back(addr);
      acc_log.push_back(addr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0; imem_rsp_data = '0; fq_rdy = 1'b0;
    br_vld = 1'b0; br_kind = 2'b00; br_taken = 1'b0; br_pc = '0; br_imm = '0; br_rdata = '0;
    flag_wr = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
    mem_pend.delete(); acc_log.delete(); m_pend.delete(); m_fq.delete();
    m_pc = RPC; m_lt = 1'b0; m_started = 1'b0; m_redirect = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl[0]  = '{1, 2'b01, 0, 64'h40, 26'h3FFFFFC, 0, 0, 0, 0, 1, 64'h30};
    tbl[1]  = '{1, 2'b11, 0, 64'h100, 26'h3, 0, 1, 1, 0, 1, 64'h10C};
    tbl[2]  = '{1, 2'b00, 0, 64'h200, 26'h10, 0, 0, 0, 0, 0, 64'h10C};
    tbl[3]  = '{1, 2'b11, 0, 64'h1000, 26'h7FFFF, 0, 0, 0, 0, 1, 64'hFFC};
    tbl[4]  = '{1, 2'b11, 0, 64'h2000, 26'h4, 0, 1, 1, 1, 0, 64'hFFC};
    tbl[5]  = '{1, 2'b11, 0, 64'h3000, 26'h4, 0, 0, 0, 0, 0, 64'hFFC};
    tbl[6]  = '{1, 2'b10, 0, 64'h50, 26'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1,
                64'hFFFF_FFFF_FFFF_FFFC};
    tbl[7]  = '{1, 2'b00, 1, 64'h8, 26'h7FFFE, 0, 0, 0, 0, 1, 64'h0};
    tbl[8]  = '{1, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFF0, 26'h8, 0, 0, 0, 0, 1, 64'h10};
    tbl[9]  = '{1, 2'b00, 1, 64'h500, 26'h3F80001, 0, 0, 0, 0, 1, 64'h504};
    tbl[10] = '{0, 2'b01, 0, 64'h0, 26'h100, 0, 0, 0, 0, 0, 64'h504};
    tbl[11] = '{1, 2'b01, 0, 64'h0, 26'h2000000, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_F800_0000};

    // Reset values are visible while reset is held.
    reset = 1'b0;
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst_req_vld", imem_req_vld, 1'b0);
    chk("rst_fq_vld", fq_vld, 1'b0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_addr", imem_addr, RPC);

    // Branch resolution vectors with memory stalled so the PC only moves on redirects.
    do_reset();
    tick();
    for (int i = 0; i < 12; i++) begin
      br_vld = tbl[i].vld; br_kind = tbl[i].kind; br_taken = tbl[i].taken;
      br_pc = tbl[i].bpc; br_imm = tbl[i].imm; br_rdata = tbl[i].rdata;
      flag_wr = tbl[i].fw; flag_n = tbl[i].fn; flag_v = tbl[i].fv;
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_req_vld", i), imem_req_vld, !tbl[i].exp_take);
      @(posedge clk);
      #1;
      br_vld = 1'b0; flag_wr = 1'b0;
      chk($sformatf("vec%0d_redirect", i), redirect, tbl[i].exp_take);
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
    end

    // Register redirect to the top of the address space, then fetch wraps to zero.
    br_vld = 1'b1; br_kind = 2'b10; br_rdata = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br_vld = 1'b0;
    imem_req_rdy = 1'b1; fq_rdy = 1'b1; rsp_pct = 100;
    acc_log.delete();
    for (int c = 0; c < 10 && acc_log.size() < 2; c++) tick();
    chk("wrap_accepts", acc_log.size(), 2);
    if (acc_log.size() >= 2) begin
      chk("wrap_first", acc_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_second", acc_log[1], 64'h0);
    end

    // Decode stalled: exactly DEPTH requests go out, then issue stops until a pop.
    do_reset();
    imem_req_rdy = 1'b1; rsp_pct = 100;
    for (int c = 0; c < 12; c++) tick();
    chk("fill_accepts", acc_log.size(), DEPTH);
    chk("fill_req_vld", imem_req_vld, 1'b0);
    chk("fill_fq_vld", fq_vld, 1'b1);
    chk("fill_head_pc", fq_pc, 64'h0);
    chk("fill_head_instr", fq_instr, word_at(64'h0));
    fq_rdy = 1'b1;
    tick();
    fq_rdy = 1'b0;
    chk("pop_req_vld", imem_req_vld, 1'b1);
    chk("pop_head_pc", fq_pc, 64'h4);

    // Asynchronous reset with three requests outstanding; their late responses are ignored.
    do_reset();
    imem_req_rdy = 1'b1; rsp_pct = 0;
    for (int c = 0; c < 20 && mem_pend.size() < 3; c++) tick();
    chk("burst_outstanding", mem_pend.size(), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_req_vld", imem_req_vld, 1'b0);
    chk("async_addr", imem_addr, RPC);
    chk("async_fq_vld", fq_vld, 1'b0);
    chk("async_redirect", redirect, 1'b0);
    imem_req_rdy = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    rsp_pct = 100;
    acc_log.delete();
    for (int c = 0; c < 4; c++) tick();
    chk("stale_fq_vld", fq_vld, 1'b0);
    imem_req_rdy = 1'b1;
    tick();
    chk("restart_accepts", acc_log.size(), 1);
    if (acc_log.size() != 0) chk("restart_addr", acc_log[0], RPC);

    // Randomized traffic against the stream model.
    do_reset();
    check_en = 1'b1;
    rsp_pct  = 60;
    for (int c = 0; c < 3000; c++) begin
      imem_req_rdy = $urandom_range(99) < 70;
      fq_rdy   = ((c % 200) < 100) ? ($urandom_range(99) < 60) : ($urandom_range(99) < 10);
      br_vld   = $urandom_range(7) == 0;
      br_kind  = 2'($urandom_range(3));
      br_taken = 1'($urandom_range(1));
      br_pc    = {$urandom, $urandom} & ~64'h3;
      br_imm   = 26'($urandom);
      br_rdata = {$urandom, $urandom};
      flag_wr  = $urandom_range(3) == 0;
      flag_n   = 1'($urandom_range(1));
      flag_v   = 1'($urandom_range(1));
      tick();
    end
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
